plate_entry: RTL and testbench

- Upstream stage of the plate-validity checker. Assembles a six-character licence plate from a serial keypad stream.
- Each character is a 4-bit code: 0x0–0x9 are digits; 0xA–0xF are letters.
- Holds the completed plate stable on m0..m5 until the consumer acknowledges it. Supports backspace, clear and idle timeout.

---
 rtl/plate_entry_pkg.sv | 18 +
 rtl/plate_entry_idle_timer.sv | 36 +++
 rtl/plate_entry.sv | 140 ++++++++++++++
 tb/tb_plate_entry.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/plate_entry_pkg.sv
// Shared constants and state type for the licence-plate entry stage.
package plate_entry_pkg;

  localparam int unsigned CHAR_W     = 4;
  localparam int unsigned PLATE_LEN  = 6;
  localparam logic [3:0]  LETTER_MIN = 4'hA;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ENTRY = 2'd1,
    FULL  = 2'd2
  } state_e;

  function automatic logic is_letter(input logic [CHAR_W-1:0] code);
    return code >= LETTER_MIN;
  endfunction

endpackage

// File: rtl/plate_entry_idle_timer.sv
// Idle counter for partial plate entry; flags expiry on the last idle cycle.
module plate_idle_timer #(
  parameter int unsigned TIMEOUT_CYC = 1000,
  parameter int unsigned CNT_W       = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic activity,
  input  logic enable,
  output logic expire
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYC - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    if (clr || activity || !enable) begin
      cnt_d = '0;
    end
  end

  assign expire = enable && !activity && (cnt_q == LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/plate_entry.sv
// Assembles a six-character plate from keypad strobes and holds it until acknowledged.
module plate_entry
  import plate_entry_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 1000,
  parameter int unsigned CNT_W       = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              key_valid,
  input  logic [CHAR_W-1:0] key_code,
  input  logic              key_del,
  input  logic              key_clr,
  input  logic              plate_ack,
  output logic [CHAR_W-1:0] m0,
  output logic [CHAR_W-1:0] m1,
  output logic [CHAR_W-1:0] m2,
  output logic [CHAR_W-1:0] m3,
  output logic [CHAR_W-1:0] m4,
  output logic [CHAR_W-1:0] m5,
  output logic [2:0]        count,
  output logic              plate_ready,
  output logic              done,
  output logic              err,
  output logic              timeout
);

  state_e            state_q, state_d;
  logic [CHAR_W-1:0] m_q [PLATE_LEN];
  logic [CHAR_W-1:0] m_d [PLATE_LEN];
  logic [2:0]        count_q, count_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              timeout_q, timeout_d;
  logic              expire;

  plate_idle_timer #(
    .TIMEOUT_CYC (TIMEOUT_CYC),
    .CNT_W       (CNT_W)
  ) u_idle_timer (
    .clk      (clk),
    .rst      (rst),
    .clr      (key_clr),
    .activity (key_valid || key_del),
    .enable   (state_q == ENTRY),
    .expire   (expire)
  );

  always_comb begin
    state_d   = state_q;
    m_d       = m_q;
    count_d   = count_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    timeout_d = 1'b0;

    if (key_clr) begin
      state_d = IDLE;
      m_d     = '{default: '0};
      count_d = '0;
    end else begin
      unique case (state_q)
        FULL: begin
          if (plate_ack) begin
            state_d = IDLE;
            m_d     = '{default: '0};
            count_d = '0;
            err_d   = key_valid;
          end else if (key_del || key_valid) begin
            err_d = 1'b1;
          end
        end
        IDLE: begin
          if (key_del) begin
            err_d = 1'b1;
          end else if (key_valid) begin
            m_d[0]  = key_code;
            count_d = 3'd1;
            state_d = ENTRY;
          end
        end
        ENTRY: begin
          if (key_del) begin
            for (int unsigned i = 0; i < PLATE_LEN; i++) begin
              if (count_q == 3'(i + 1)) m_d[i] = '0;
            end
            count_d = count_q - 3'd1;
            if (count_q == 3'd1) state_d = IDLE;
          end else if (key_valid) begin
            for (int unsigned i = 0; i < PLATE_LEN; i++) begin
              if (count_q == 3'(i)) m_d[i] = key_code;
            end
            count_d = count_q + 3'd1;
            if (count_q == 3'(PLATE_LEN - 1)) begin
              state_d = FULL;
              done_d  = 1'b1;
            end
          end else if (expire) begin
            state_d   = IDLE;
            m_d       = '{default: '0};
            count_d   = '0;
            timeout_d = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      m_q       <= '{default: '0};
      count_q   <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      m_q       <= m_d;
      count_q   <= count_d;
      done_q    <= done_d;
      err_q     <= err_d;
      timeout_q <= timeout_d;
    end
  end

  assign m0          = m_q[0];
  assign m1          = m_q[1];
  assign m2          = m_q[2];
  assign m3          = m_q[3];
  assign m4          = m_q[4];
  assign m5          = m_q[5];
  assign count       = count_q;
  assign plate_ready = (state_q == FULL);
  assign done        = done_q;
  assign err         = err_q;
  assign timeout     = timeout_q;

endmodule

// File: tb/tb_plate_entry.sv
// Bench for plate_entry: queue-based plate model checked every cycle, plus directed scenarios.
module tb_plate_entry;

  localparam int T = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       key_valid = 1'b0;
  logic [3:0] key_code = 4'h0;
  logic       key_del = 1'b0;
  logic       key_clr = 1'b0;
  logic       plate_ack = 1'b0;
  logic [3:0] m0, m1, m2, m3, m4, m5;
  logic [2:0] count;
  logic       plate_ready, done, err, timeout;

  plate_entry #(
    .TIMEOUT_CYC (T),
    .CNT_W       (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .key_valid   (key_valid),
    .key_code    (key_code),
    .key_del     (key_del),
    .key_clr     (key_clr),
    .plate_ack   (plate_ack),
    .m0          (m0),
    .m1          (m1),
    .m2          (m2),
    .m3          (m3),
    .m4          (m4),
    .m5          (m5),
    .count       (count),
    .plate_ready (plate_ready),
    .done        (done),
    .err         (err),
    .timeout     (timeout)
  );

  always #5 clk = ~clk;

  int pass_cnt = 0;
  int total_cnt = 0;
  bit checking = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Reference model: the plate is a queue of characters; idle is the count of quiet cycles.
  logic [3:0] plate[$];
  int         idle = 0;
  bit         exp_done = 0, exp_err = 0, exp_to = 0;

  function automatic logic [3:0] exp_m(input int i);
    return (i < plate.size()) ? plate[i] : 4'h0;
  endfunction

  always @(posedge clk) begin
    exp_done = 0;
    exp_err  = 0;
    exp_to   = 0;
    if (rst || key_clr) begin
      plate.delete();
      idle = 0;
    end else if (plate.size() == 6) begin
      if (plate_ack) begin
        plate.delete();
        exp_err = key_valid;
      end else if (key_del || key_valid) begin
        exp_err = 1;
      end
    end else if (key_del) begin
      if (plate.size() == 0) exp_err = 1;
      else void'(plate.pop_back());
      idle = 0;
    end else if (key_valid) begin
      plate.push_back(key_code);
      idle = 0;
      if (plate.size() == 6) exp_done = 1;
    end else if (plate.size() > 0) begin
      if (idle == T - 1) begin
        plate.delete();
        idle = 0;
        exp_to = 1;
      end else begin
        idle++;
      end
    end
  end

  always @(negedge clk) begin
    if (checking) begin
      check("m0", m0, exp_m(0));
      check("m1", m1, exp_m(1));
      check("m2", m2, exp_m(2));
      check("m3", m3, exp_m(3));
      check("m4", m4, exp_m(4));
      check("m5", m5, exp_m(5));
      check("count", count, plate.size());
      check("plate_ready", plate_ready, plate.size() == 6);
      check("done", done, exp_done);
      check("err", err, exp_err);
      check("timeout", timeout, exp_to);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic key(input logic [3:0] c);
    key_valid = 1'b1;
    key_code  = c;
    cyc();
    key_valid = 1'b0;
  endtask

  task automatic del();
    key_del = 1'b1;
    cyc();
    key_del = 1'b0;
  endtask

  task automatic clr();
    key_clr = 1'b1;
    cyc();
    key_clr = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    cyc();
    cyc();
    checking = 1'b1;
    check("rst_count", count, 0);
    check("rst_m0", m0, 0);
    check("rst_ready", plate_ready, 0);
    check("rst_done", done, 0);
    rst = 1'b0;

    // Full plate, hold, reject extra key, ack with simultaneous key.
    key(4'hA); key(4'hB); key(4'h1); key(4'h2); key(4'hC); key(4'hD);
    check("full_count", count, 6);
    check("full_m0", m0, 4'hA);
    check("full_m2", m2, 4'h1);
    check("full_m5", m5, 4'hD);
    check("full_done", done, 1);
    check("full_ready", plate_ready, 1);
    repeat (T + 3) cyc();
    check("hold_done", done, 0);
    check("hold_ready", plate_ready, 1);
    check("hold_m4", m4, 4'hC);
    key(4'h9);
    check("full_key_err", err, 1);
    check("full_key_m5", m5, 4'hD);
    check("full_key_count", count, 6);
    plate_ack = 1'b1;
    key(4'h5);
    plate_ack = 1'b0;
    check("ack_count", count, 0);
    check("ack_err", err, 1);
    check("ack_ready", plate_ready, 0);
    check("ack_m0", m0, 0);

    // Backspace then continue.
    key(4'h3); key(4'h4); key(4'h5); del(); key(4'h7);
    check("del_m0", m0, 4'h3);
    check("del_m1", m1, 4'h4);
    check("del_m2", m2, 4'h7);
    check("del_m3", m3, 4'h0);
    check("del_count", count, 3);
    key(4'h8);
    clr();
    check("clr_count", count, 0);
    check("clr_m3", m3, 0);
    check("clr_err", err, 0);
    del();
    check("del0_err", err, 1);
    check("del0_count", count, 0);

    // Timeout lands T edges after the last key.
    key(4'h1); key(4'h2);
    repeat (T - 1) cyc();
    check("to_pre", timeout, 0);
    check("to_pre_count", count, 2);
    cyc();
    check("to_pulse", timeout, 1);
    check("to_count", count, 0);
    cyc();
    check("to_once", timeout, 0);

    // A key on the seventh idle cycle restarts the count.
    key(4'h1); key(4'h2);
    repeat (T - 2) cyc();
    key(4'h3);
    repeat (T - 1) cyc();
    check("rs_pre", timeout, 0);
    check("rs_count", count, 3);
    cyc();
    check("rs_pulse", timeout, 1);

    // Reset beats a same-cycle key.
    key(4'h1); key(4'h2); key(4'h3);
    rst = 1'b1;
    key(4'hF);
    rst = 1'b0;
    check("rk_count", count, 0);
    check("rk_m0", m0, 0);
    check("rk_err", err, 0);

    // Random phase, with quiet stretches to exercise the timer.
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 15) == 0) begin
        repeat ($urandom_range(T - 2, T + 2)) cyc();
      end
      key_valid = ($urandom_range(0, 99) < 45);
      key_code  = 4'($urandom_range(0, 15));
      key_del   = ($urandom_range(0, 99) < 12);
      key_clr   = ($urandom_range(0, 99) < 3);
      plate_ack = ($urandom_range(0, 99) < 20);
      rst       = ($urandom_range(0, 199) == 0);
      cyc();
      key_valid = 1'b0;
      key_del   = 1'b0;
      key_clr   = 1'b0;
      plate_ack = 1'b0;
      rst       = 1'b0;
    end

    cyc();
    checking = 1'b0;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
